// File: rtl/dds_amp_ctrl.sv
// Output conditioning between DDS core and DAC: slew-limited amplitude scaling, rounding, saturation, offset-binary.
// Latency: 3 dac_clk cycles from wave_in/amp_cur to dac_data; amp_cur updates 1 cycle after its inputs.
// Backpressure: none; streaming every cycle, wave_rdy low forces zero output and zero amplitude.
module dds_amp_ctrl #(
    parameter int DAC_WIDTH = 14,
    parameter int AMP_WIDTH = 16,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 dac_clk,
    input  logic                 rstn,
    input  logic                 wave_rdy,
    input  logic [DAC_WIDTH-1:0] wave_in_1,
    input  logic [DAC_WIDTH-1:0] wave_in_2,
    input  logic                 amp_wen,
    input  logic [31:0]          amp_target,
    input  logic [31:0]          slew_step,
    input  logic [31:0]          slew_div,
    input  logic                 mute,
    output logic [DAC_WIDTH-1:0] dac_data_1,
    output logic [DAC_WIDTH-1:0] dac_data_2,
    output logic [AMP_WIDTH-1:0] amp_cur,
    output logic                 settled
);

    localparam int PW = DAC_WIDTH + AMP_WIDTH + 1;
    localparam logic [DAC_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] RND     = PW'(2 ** (AMP_WIDTH - 1));
    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (DAC_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -PW'(2 ** (DAC_WIDTH - 1));

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_t;

    logic [AMP_WIDTH-1:0] r_target_buf;
    logic [AMP_WIDTH-1:0] r_step_buf;
    logic [DIV_WIDTH-1:0] r_div_buf;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [AMP_WIDTH-1:0] r_amp_cur;
    state_t               r_state;
    logic                 r_settled;

    logic signed [DAC_WIDTH-1:0] r_w1_s1;
    logic signed [DAC_WIDTH-1:0] r_w2_s1;
    logic [AMP_WIDTH-1:0]        r_amp_s1;
    logic signed [PW-1:0]        r_p1_s2;
    logic signed [PW-1:0]        r_p2_s2;
    logic [DAC_WIDTH-1:0]        r_dac_1;
    logic [DAC_WIDTH-1:0]        r_dac_2;

    logic [AMP_WIDTH-1:0] w_eff_target;
    logic                 w_tick;
    logic [AMP_WIDTH:0]   w_sum;
    logic [AMP_WIDTH:0]   w_diff;
    logic [AMP_WIDTH-1:0] w_up_val;
    logic [AMP_WIDTH-1:0] w_dn_val;
    logic [AMP_WIDTH-1:0] w_amp_next;
    logic signed [PW-1:0] w_w1_ext;
    logic signed [PW-1:0] w_w2_ext;
    logic signed [PW-1:0] w_amp_ext;

    // Upper input bits and the debug-only state register are intentionally not consumed.
    logic w_unused;
    assign w_unused = ^{amp_target[31:AMP_WIDTH], slew_step[31:AMP_WIDTH],
                        slew_div[31:DIV_WIDTH], r_state};

    // Muting or losing the wave source both steer the amplitude towards zero.
    assign w_eff_target = (mute | ~wave_rdy) ? '0 : r_target_buf;
    assign w_tick       = (r_cnt == r_div_buf);

    // One extra bit on both sides so the step can never wrap past full scale or below zero.
    assign w_sum    = {1'b0, r_amp_cur} + {1'b0, r_step_buf};
    assign w_diff   = {1'b0, r_amp_cur} - {1'b0, r_step_buf};
    assign w_up_val = (w_sum >= {1'b0, w_eff_target}) ? w_eff_target : w_sum[AMP_WIDTH-1:0];
    assign w_dn_val = (w_diff[AMP_WIDTH] || (w_diff[AMP_WIDTH-1:0] < w_eff_target))
                      ? w_eff_target : w_diff[AMP_WIDTH-1:0];

    // Next amplitude: hard zero on source loss, jump when step is zero, otherwise slew on ticks.
    always_comb begin
        w_amp_next = r_amp_cur;
        if (!wave_rdy) begin
            w_amp_next = '0;
        end else if (r_step_buf == '0) begin
            w_amp_next = w_eff_target;
        end else if (w_tick) begin
            if (r_amp_cur < w_eff_target) begin
                w_amp_next = w_up_val;
            end else if (r_amp_cur > w_eff_target) begin
                w_amp_next = w_dn_val;
            end
        end
    end

    // Parameter buffers and tick divider; a write restarts the tick period.
    always_ff @(posedge dac_clk) begin
        if (!rstn) begin
            r_target_buf <= '0;
            r_step_buf   <= '0;
            r_div_buf    <= '0;
            r_cnt        <= '0;
        end else begin
            if (amp_wen) begin
                r_target_buf <= amp_target[AMP_WIDTH-1:0];
                r_step_buf   <= slew_step[AMP_WIDTH-1:0];
                r_div_buf    <= slew_div[DIV_WIDTH-1:0];
            end
            if (amp_wen || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Amplitude register and ramp-state FSM, judged on the registered amplitude vs effective target.
    always_ff @(posedge dac_clk) begin
        if (!rstn) begin
            r_amp_cur <= '0;
            r_state   <= MUTED;
            r_settled <= 1'b1;
        end else begin
            r_amp_cur <= w_amp_next;
            if (r_amp_cur < w_eff_target) begin
                r_state   <= RAMP_UP;
                r_settled <= 1'b0;
            end else if (r_amp_cur > w_eff_target) begin
                r_state   <= RAMP_DOWN;
                r_settled <= 1'b0;
            end else if (r_amp_cur == '0) begin
                r_state   <= MUTED;
                r_settled <= 1'b1;
            end else begin
                r_state   <= HOLD;
                r_settled <= 1'b1;
            end
        end
    end

    // Round half up, clamp to the DAC range, then flip the sign bit for offset binary.
    function automatic logic [DAC_WIDTH-1:0] f_to_dac(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] v;
        v = (p + RND) >>> AMP_WIDTH;
        if (v > SAT_MAX) begin
            v = SAT_MAX;
        end else if (v < SAT_MIN) begin
            v = SAT_MIN;
        end
        return {~v[DAC_WIDTH-1], v[DAC_WIDTH-2:0]};
    endfunction

    assign w_w1_ext  = PW'(r_w1_s1);
    assign w_w2_ext  = PW'(r_w2_s1);
    assign w_amp_ext = PW'($signed({1'b0, r_amp_s1}));

    // Three-stage datapath; both channels share one amplitude sample so they stay aligned.
    always_ff @(posedge dac_clk) begin
        if (!rstn) begin
            r_w1_s1  <= '0;
            r_w2_s1  <= '0;
            r_amp_s1 <= '0;
            r_p1_s2  <= '0;
            r_p2_s2  <= '0;
            r_dac_1  <= MIDSCALE;
            r_dac_2  <= MIDSCALE;
        end else begin
            r_w1_s1  <= wave_rdy ? $signed(wave_in_1) : '0;
            r_w2_s1  <= wave_rdy ? $signed(wave_in_2) : '0;
            r_amp_s1 <= r_amp_cur;
            r_p1_s2  <= w_w1_ext * w_amp_ext;
            r_p2_s2  <= w_w2_ext * w_amp_ext;
            r_dac_1  <= f_to_dac(r_p1_s2);
            r_dac_2  <= f_to_dac(r_p2_s2);
        end
    end

    assign dac_data_1 = r_dac_1;
    assign dac_data_2 = r_dac_2;
    assign amp_cur    = r_amp_cur;
    assign settled    = r_settled;

endmodule

// File: tb/tb_dds_amp_ctrl.sv
// Randomised and directed bench for dds_amp_ctrl against an arithmetic reference model.
// Model is stepped on each rising edge; outputs are compared 1 time unit later.
// Inputs change only after the compare point, never near the active edge.
module tb_dds_amp_ctrl;

    logic        dac_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wave_rdy = 1'b0;
    logic [13:0] wave_in_1 = '0;
    logic [13:0] wave_in_2 = '0;
    logic        amp_wen = 1'b0;
    logic [31:0] amp_target = '0;
    logic [31:0] slew_step = '0;
    logic [31:0] slew_div = '0;
    logic        mute = 1'b0;
    logic [13:0] dac_data_1;
    logic [13:0] dac_data_2;
    logic [15:0] amp_cur;
    logic        settled;

    int errors = 0;
    int checks = 0;

    // Reference model state (plain integers)
    int m_tgt, m_step, m_div, m_cnt, m_amp;
    int m_settled;
    int h_w1 [3];
    int h_w2 [3];
    int h_a  [3];

    always #5 dac_clk = ~dac_clk;

    dds_amp_ctrl dut (
        .dac_clk   (dac_clk),
        .rstn      (rstn),
        .wave_rdy  (wave_rdy),
        .wave_in_1 (wave_in_1),
        .wave_in_2 (wave_in_2),
        .amp_wen   (amp_wen),
        .amp_target(amp_target),
        .slew_step (slew_step),
        .slew_div  (slew_div),
        .mute      (mute),
        .dac_data_1(dac_data_1),
        .dac_data_2(dac_data_2),
        .amp_cur   (amp_cur),
        .settled   (settled)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ideal scaling: round(w*a/65536) half up, clamp to 14-bit signed, add midscale offset.
    function automatic int to_dac(input int w, input int a);
        longint p;
        p = (longint'(w) * longint'(a) + 32768) >>> 16;
        if (p > 8191)  p = 8191;
        if (p < -8192) p = -8192;
        return int'(p) + 8192;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_edge();
        int eff;
        int namp;
        bit tick;
        if (!rstn) begin
            m_tgt = 0; m_step = 0; m_div = 0; m_cnt = 0; m_amp = 0; m_settled = 1;
            for (int i = 0; i < 3; i++) begin
                h_w1[i] = 0; h_w2[i] = 0; h_a[i] = 0;
            end
        end else begin
            eff  = (mute || !wave_rdy) ? 0 : m_tgt;
            tick = (m_cnt == m_div);
            for (int i = 2; i > 0; i--) begin
                h_w1[i] = h_w1[i-1]; h_w2[i] = h_w2[i-1]; h_a[i] = h_a[i-1];
            end
            h_w1[0] = wave_rdy ? int'($signed(wave_in_1)) : 0;
            h_w2[0] = wave_rdy ? int'($signed(wave_in_2)) : 0;
            h_a[0]  = m_amp;
            if (!wave_rdy)          namp = 0;
            else if (m_step == 0)   namp = eff;
            else if (!tick)         namp = m_amp;
            else if (m_amp < eff)   namp = imin(m_amp + m_step, eff);
            else if (m_amp > eff)   namp = imax(m_amp - m_step, eff);
            else                    namp = m_amp;
            m_settled = (m_amp == eff) ? 1 : 0;
            m_cnt = (amp_wen || tick) ? 0 : m_cnt + 1;
            if (amp_wen) begin
                m_tgt  = int'(amp_target[15:0]);
                m_step = int'(slew_step[15:0]);
                m_div  = int'(slew_div[15:0]);
            end
            m_amp = namp;
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs shortly after.
    task automatic cyc();
        @(posedge dac_clk);
        model_edge();
        #1;
        check("amp_cur", 32'(amp_cur), 32'(m_amp));
        check("settled", 32'(settled), 32'(m_settled));
        check("dac1", 32'(dac_data_1), 32'(to_dac(h_w1[2], h_a[2])));
        check("dac2", 32'(dac_data_2), 32'(to_dac(h_w2[2], h_a[2])));
    endtask

    task automatic write_amp(input logic [31:0] t, input logic [31:0] s, input logic [31:0] d);
        amp_target = t; slew_step = s; slew_div = d; amp_wen = 1'b1;
        cyc();
        amp_wen = 1'b0;
    endtask

    initial begin
        // Reset
        rstn = 1'b0;
        cyc(); cyc();
        check("rst_dac1", 32'(dac_data_1), 32'h2000);
        check("rst_dac2", 32'(dac_data_2), 32'h2000);
        check("rst_amp", 32'(amp_cur), 32'h0);
        check("rst_settled", 32'(settled), 32'h1);
        rstn = 1'b1;

        // Immediate full-scale amplitude
        wave_rdy = 1'b1; wave_in_1 = 14'h1000; wave_in_2 = 14'h3000;
        write_amp(32'hFFFF, 32'h0, 32'h0);
        cyc();
        check("imm_amp", 32'(amp_cur), 32'hFFFF);
        repeat (3) cyc();
        check("imm_dac1", 32'(dac_data_1), 32'h3000);

        // Slewed ramp 0 -> 0x400, tick every 4 cycles
        write_amp(32'h0, 32'h0, 32'h0);
        cyc();
        write_amp(32'h400, 32'h100, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            repeat (4) cyc();
            check("ramp_amp", 32'(amp_cur), 32'(k * 32'h100));
            if (k == 1) check("ramp_settled", 32'(settled), 32'h0);
        end
        cyc();
        check("ramp_done_settled", 32'(settled), 32'h1);

        // No overshoot on a partial step
        write_amp(32'h450, 32'h100, 32'h3);
        repeat (4) cyc();
        check("no_overshoot", 32'(amp_cur), 32'h450);

        // Negative full-scale at half amplitude, then muted ramp down
        wave_in_1 = 14'h2000;
        write_amp(32'h8000, 32'h0, 32'h0);
        repeat (4) cyc();
        check("neg_half_dac1", 32'(dac_data_1), 32'h1000);
        write_amp(32'h8000, 32'h100, 32'h0);
        mute = 1'b1;
        cyc();
        check("mute_step", 32'(amp_cur), 32'h7F00);
        repeat (128) cyc();
        check("mute_amp", 32'(amp_cur), 32'h0);
        repeat (3) cyc();
        check("mute_dac1", 32'(dac_data_1), 32'h2000);
        check("mute_settled", 32'(settled), 32'h1);

        // Source loss mid-hold, then reset mid-ramp
        mute = 1'b0;
        repeat (140) cyc();
        wave_rdy = 1'b0;
        cyc();
        check("rdy_drop_amp", 32'(amp_cur), 32'h0);
        repeat (3) cyc();
        check("rdy_drop_dac1", 32'(dac_data_1), 32'h2000);
        wave_rdy = 1'b1;
        repeat (5) cyc();
        rstn = 1'b0;
        cyc();
        check("rst_mid_amp", 32'(amp_cur), 32'h0);
        rstn = 1'b1;
        repeat (3) cyc();
        check("rst_clears_buf", 32'(amp_cur), 32'h0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            wave_in_1 = 14'($urandom);
            wave_in_2 = ($urandom_range(0, 7) == 0) ? 14'h2000 : 14'($urandom);
            amp_wen = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                amp_wen = 1'b1;
                case ($urandom_range(0, 3))
                    0:       amp_target = {16'($urandom), 16'hFFFF};
                    1:       amp_target = {16'($urandom), 16'h0};
                    default: amp_target = $urandom;
                endcase
                case ($urandom_range(0, 3))
                    0:       slew_step = {16'($urandom), 16'h0};
                    1:       slew_step = $urandom;
                    default: slew_step = {16'($urandom), 16'($urandom_range(1, 2048))};
                endcase
                slew_div = {16'($urandom), 16'($urandom_range(0, 4))};
            end
            if ($urandom_range(0, 59) == 0) mute = ~mute;
            wave_rdy = ($urandom_range(0, 49) != 0);
            rstn = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_amp_ctrl.md
Name: dds_amp_ctrl

Overview:
- Output-conditioning stage between the DDS core and the DAC pins. Consumes the two signed quadrature waves from the phase-to-amplitude core and the 32-bit amplitude word from the mode mux.
- Scales both waves by a slew-limited amplitude to avoid clicks, rounds, saturates, and converts to offset-binary DAC codes.
- Runs in the DAC clock domain.

Parameters:
DAC_WIDTH, 14, width of wave inputs and DAC outputs
AMP_WIDTH, 16, amplitude resolution; unsigned scale, 2^AMP_WIDTH-1 ≈ unity
DIV_WIDTH, 16, width of slew tick divider

Ports:
dac_clk  input  1  clock; all logic on rising edge
rstn  input  1  reset, synchronous, active-low
wave_rdy  input  1  DDS core output valid
wave_in_1  input  DAC_WIDTH  cos wave, signed two's complement
wave_in_2  input  DAC_WIDTH  sin wave, signed two's complement
amp_wen  input  1  one-cycle strobe; latches amp_target, slew_step, slew_div
amp_target  input  32  target amplitude; bits [AMP_WIDTH-1:0] used
slew_step  input  32  amplitude change per tick; bits [AMP_WIDTH-1:0] used
slew_div  input  32  tick period minus 1; bits [DIV_WIDTH-1:0] used
mute  input  1  level; drives effective target to 0
dac_data_1  output  DAC_WIDTH  offset-binary DAC code, channel 1
dac_data_2  output  DAC_WIDTH  offset-binary DAC code, channel 2
amp_cur  output  AMP_WIDTH  current applied amplitude
settled  output  1  amp_cur equals effective target

Behaviour:
- Reset (rstn low at an edge):
  - target_buf, step_buf, div_buf, amp_cur, and tick counter go to 0.
  - State goes to MUTED; settled=1.
  - dac_data_1/2 = 1<<(DAC_WIDTH-1) (0x2000); all pipeline stages are flushed to midscale.
  - Reset mid-ramp aborts the ramp with no residual state.
- Parameter latch:
  - On amp_wen, buffers load from the low bits of the inputs, and the tick counter clears.
  - The new target is effective from the next cycle and the ramp direction is recomputed then.
- eff_target = (mute | !wave_rdy) ? 0 : target_buf.
- Tick generation:
  - The counter counts 0..div_buf, and tick is asserted when count==div_buf, after which the counter wraps to 0.
  - div_buf=0 gives a tick every cycle.
- Slew, applied on a tick:
  - amp_cur<eff_target: amp_cur = min(amp_cur+step_buf, eff_target), computed at AMP_WIDTH+1 bits so it never wraps.
  - amp_cur>eff_target: amp_cur = max(amp_cur-step_buf, eff_target), with no underflow.
  - step_buf=0 means immediate: amp_cur = eff_target on the next cycle regardless of tick.
  - wave_rdy low forces amp_cur=0 on the next cycle (no ramp).
- FSM, evaluated each cycle on the registered amp_cur and eff_target:
  - MUTED: amp_cur==0 and eff_target==0.
  - RAMP_UP: amp_cur<eff_target.
  - RAMP_DOWN: amp_cur>eff_target.
  - HOLD: amp_cur==eff_target!=0.
  - settled=1 in MUTED and HOLD.
  - A target change during a ramp redirects the ramp with no pause.
- Datapath, 3-cycle latency from wave_in/amp_cur to dac_data:
  - S1: register wave_in_1/2 (replaced by 0 when wave_rdy=0) and amp_cur.
  - S2: signed product wave × {1'b0,amp}, DAC_WIDTH+AMP_WIDTH+1 bits.
  - S3:
    - Add 1<<(AMP_WIDTH-1), arithmetic shift right by AMP_WIDTH (round half up).
    - Saturate to [-2^(DAC_WIDTH-1), 2^(DAC_WIDTH-1)-1].
    - Invert the MSB to produce offset binary.
- Both channels share amp_cur and remain cycle-aligned.
- mute and amp_wen asserted in the same cycle: the buffers latch and the ramp heads to 0; on mute release the ramp heads to the new target.

Test Plan:
1. Assert rstn=0 for 2 cycles -> dac_data_1/2=0x2000, amp_cur=0, settled=1.
2. wave_rdy=1, amp_wen with target=0xFFFF, step=0, wave_in_1=0x1000 -> amp_cur=0xFFFF one cycle later; dac_data_1=0x3000 three cycles after that.
3. amp_wen with target=0x0400, step=0x0100, div=3 -> amp_cur reaches 0x100, 0x200, 0x300, 0x400 at 4-cycle spacing; settled=0 during the ramp and 1 once amp_cur=0x400.
4. From amp_cur=0x0400, amp_wen with target=0x0450, step=0x0100 -> amp_cur=0x0450 on the first tick, with no overshoot.
5. wave_in_1=-8192, amp=0x8000 -> dac_data_1=0x1000. Then raise mute, div=0, step=0x0100 -> amp_cur falls by 0x100 per cycle to 0, MUTED, dac_data=0x2000.
6. Drop wave_rdy mid-HOLD, then pulse rstn low mid-ramp -> amp_cur=0 on the next cycle and outputs return to 0x2000 within 3 cycles; reset clears all buffers.
